// File: rtl/fifo_pkt_wr_ctrl.sv
// Packet write controller for a pointer-resettable fifo_sync: writes framed beats,
// rewinds the write pointer on drop/error, publishes committed pointer and count.
// Optional statistics outputs (drop_cnt, err_cnt) under FIFO_PKT_WR_CTRL_STATS_EN.
module fifo_pkt_wr_ctrl #(
  parameter int ADDR_WIDTH    = 11,
  parameter int W_EL          = 20,
  parameter int MAX_PKT_BEATS = 64,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W_EL-1:0]       in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_drop,
  output logic                  fifo_wen,
  output logic [W_EL-1:0]       fifo_wdata,
  input  logic                  fifo_full,
  input  logic [ADDR_WIDTH:0]   fifo_wptr,
  output logic                  fifo_wrst,
  output logic [ADDR_WIDTH:0]   fifo_rst_wptr,
  output logic [ADDR_WIDTH:0]   commit_wptr,
  output logic [CNT_WIDTH-1:0]  pkt_avail,
  input  logic                  pkt_rd_done
`ifdef FIFO_PKT_WR_CTRL_STATS_EN
  ,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           err_cnt
`endif
);

  localparam int BW = $clog2(MAX_PKT_BEATS + 2);

  if (MAX_PKT_BEATS >= (1 << ADDR_WIDTH)) begin : g_bad_max_pkt
    $error("MAX_PKT_BEATS must be smaller than the FIFO depth");
  end

  typedef enum logic [1:0] {IDLE, WRITE, DRAIN, REWIND} state_t;

  state_t              state;
  logic [ADDR_WIDTH:0] start_ptr;
  logic [BW-1:0]       beat_cnt;
  logic                acc;
  logic                frame_err;
  logic                oversize;
  logic                legal;
  logic                commit;
  logic                rd_dec;

  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      IDLE, WRITE: in_ready = !fifo_full;
      DRAIN:       in_ready = 1'b1;
      default:     in_ready = 1'b0;
    endcase
    if (reset) in_ready = 1'b0;
  end

  assign acc       = in_valid & in_ready;
  assign frame_err = (state == WRITE) & in_sop;
  // eop at the limit is still legal; only a continuing beat overflows
  assign oversize  = (state == WRITE) & !in_sop & !in_eop & (beat_cnt == BW'(MAX_PKT_BEATS));
  assign legal     = ((state == IDLE) & in_sop) | ((state == WRITE) & !in_sop & !oversize);
  assign fifo_wen  = acc & legal;
  assign commit    = acc & legal & in_eop & !in_drop;
  assign rd_dec    = pkt_rd_done & (pkt_avail != '0);

  assign fifo_wdata    = in_data;
  assign fifo_wrst     = (state == REWIND);
  assign fifo_rst_wptr = start_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      start_ptr   <= '0;
      beat_cnt    <= '0;
      commit_wptr <= '0;
      pkt_avail   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc && in_sop) begin
            if (!in_eop) begin
              start_ptr <= fifo_wptr;
              beat_cnt  <= BW'(1);
              state     <= WRITE;
            end else if (in_drop) begin
              start_ptr <= fifo_wptr;
              state     <= REWIND;
            end
          end
        end
        WRITE: begin
          if (acc) begin
            if (in_sop) begin
              state <= in_eop ? REWIND : DRAIN;
            end else if (oversize) begin
              state <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              if (in_eop) state <= in_drop ? REWIND : IDLE;
            end
          end
        end
        DRAIN: begin
          if (acc && in_eop) state <= REWIND;
        end
        default: state <= IDLE;
      endcase

      if (commit) commit_wptr <= fifo_wptr + 1'b1;

      if (commit && !rd_dec) begin
        if (pkt_avail != '1) pkt_avail <= pkt_avail + 1'b1;
      end else if (!commit && rd_dec) begin
        pkt_avail <= pkt_avail - 1'b1;
      end
    end
  end

`ifdef FIFO_PKT_WR_CTRL_STATS_EN
  logic enter_rewind;
  logic err_evt;

  // WRITE goes to REWIND on a framing error with eop, or on a legal eop with drop
  assign enter_rewind = acc & (((state == IDLE) & in_sop & in_eop & in_drop) |
                               ((state == WRITE) & in_eop & (in_sop | in_drop)) |
                               ((state == DRAIN) & in_eop));
  assign err_evt      = acc & (((state == IDLE) & !in_sop) | frame_err | oversize);

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (enter_rewind && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (err_evt && err_cnt != '1)       err_cnt  <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
